// File: rtl/controle_jogo_pkg.sv
// Shared definitions for the sequence-memory game controller.
// Holds the FSM state codes, default timing values and small elaboration helpers,
// so the datapath and the benches decode db_estado the same way the controller does.
package controle_jogo_pkg;

    // State codes are visible on db_estado, so their values are fixed.
    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        MOSTRA      = 4'h2,
        APAGA       = 4'h3,
        ESPERA      = 4'h4,
        REGISTRA    = 4'h5,
        COMPARA     = 4'h6,
        PROXIMA     = 4'h7,
        NOVA_RODADA = 4'h8,
        GANHOU      = 4'hA,
        TIMEOUT     = 4'hD,
        PERDEU      = 4'hE
    } estado_t;

    // Default timing, in clock cycles at the nominal 1 kHz clock.
    localparam int T_LED_DEF     = 500;
    localparam int T_APAGADO_DEF = 250;
    localparam int T_TIMEOUT_DEF = 3000;

    // Index of the last round for each difficulty setting.
    localparam logic [3:0] ULTIMA_FACIL   = 4'd3;
    localparam logic [3:0] ULTIMA_DIFICIL = 4'd15;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int largura(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/controle_jogo_if.sv
// Signal bundle between the game controller and its datapath.
// master: controller side (drives control/status, reads play results).
// slave : datapath/bench side (drives requests and compare results).
interface controle_jogo_if;

    // requests and play results towards the controller
    logic       jogar;
    logic       dificuldade;
    logic       memoria;
    logic       tem_jogada;
    logic       igual;

    // control and status from the controller
    logic [3:0] endereco;
    logic       banco;
    logic       mostra_leds;
    logic       led_aceso;
    logic       registra;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
    logic       timeout;
    logic [3:0] db_rodada;
    logic [3:0] db_estado;

    modport master (
        input  jogar, dificuldade, memoria, tem_jogada, igual,
        output endereco, banco, mostra_leds, led_aceso, registra,
               pronto, ganhou, perdeu, timeout, db_rodada, db_estado
    );

    modport slave (
        output jogar, dificuldade, memoria, tem_jogada, igual,
        input  endereco, banco, mostra_leds, led_aceso, registra,
               pronto, ganhou, perdeu, timeout, db_rodada, db_estado
    );

endinterface

// File: rtl/controle_jogo_contador.sv
// Modulus-M up counter with synchronous clear, count enable and terminal flag.
// Latency: q updates one clock after clr/en; fim is combinational from q.
// No backpressure: counts whenever en is high, wrapping from M-1 to 0.
// Ports: clock; clr (sync clear, wins over en); en; q (count); fim (q == M-1).
module contador_m #(
    parameter int M = 16,
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         fim
);

    assign fim = (q == W'(M - 1));

    always_ff @(posedge clock) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= fim ? '0 : q + W'(1);
        end
    end

endmodule

// File: rtl/controle_jogo.sv
// Sequence-memory game controller: shows the sequence per round, waits for plays, judges.
// Latency: Moore outputs, all registered state; decisions take effect one clock later.
// No backpressure: tem_jogada is a one-cycle pulse, only accepted while waiting for a play.
// Ports: clock, reset (sync, active-high); bus (master side of controle_jogo_if):
//   in : jogar, dificuldade, memoria, tem_jogada, igual
//   out: endereco, banco, mostra_leds, led_aceso, registra, pronto, ganhou, perdeu,
//        timeout, db_rodada, db_estado
module controle_jogo
    import controle_jogo_pkg::*;
#(
    parameter int T_LED     = T_LED_DEF,
    parameter int T_APAGADO = T_APAGADO_DEF,
    parameter int T_TIMEOUT = T_TIMEOUT_DEF
) (
    input  logic            clock,
    input  logic            reset,
    controle_jogo_if.master bus
);

    // The timer is sized to hold the largest interval value itself.
    localparam int T_MAX = max3(T_LED, T_APAGADO, T_TIMEOUT);
    localparam int TW    = largura(T_MAX + 1);

    estado_t       estado;
    estado_t       prox;

    logic [TW-1:0] timer;
    logic          timer_fim;
    logic [3:0]    jogada;
    logic          jogada_fim;
    logic [3:0]    rodada;
    logic          rodada_fim;

    logic [3:0]    ultima;
    logic          banco_q;

    logic          jog_clr;
    logic          jog_inc;
    logic          rod_inc;

    logic          led_fim;
    logic          apagado_fim;
    logic          espera_fim;

    // The timer restarts at 0 on every state change, so each comparison
    // below measures cycles spent in the current state.
    assign led_fim     = (timer == TW'(T_LED - 1));
    assign apagado_fim = (timer == TW'(T_APAGADO - 1));
    assign espera_fim  = (timer == TW'(T_TIMEOUT - 1));

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= prox;
        end
    end

    // ---------------------------------------------------------------
    // Next state and counter strobes
    // ---------------------------------------------------------------
    always_comb begin
        prox    = estado;
        jog_clr = 1'b0;
        jog_inc = 1'b0;
        rod_inc = 1'b0;

        case (estado)
            INICIAL: begin
                if (bus.jogar) begin
                    prox = PREPARA;
                end
            end

            PREPARA: begin
                jog_clr = 1'b1;
                prox    = MOSTRA;
            end

            MOSTRA: begin
                if (led_fim) begin
                    prox = APAGA;
                end
            end

            // After the dark gap either show the next LED of this round
            // or, once every LED up to the round index is shown, wait for plays.
            APAGA: begin
                if (apagado_fim) begin
                    if (jogada == rodada) begin
                        jog_clr = 1'b1;
                        prox    = ESPERA;
                    end else begin
                        jog_inc = 1'b1;
                        prox    = MOSTRA;
                    end
                end
            end

            // A play on the very last allowed cycle still counts.
            ESPERA: begin
                if (bus.tem_jogada) begin
                    prox = REGISTRA;
                end else if (espera_fim) begin
                    prox = TIMEOUT;
                end
            end

            REGISTRA: begin
                prox = COMPARA;
            end

            COMPARA: begin
                if (!bus.igual) begin
                    prox = PERDEU;
                end else if (jogada < rodada) begin
                    prox = PROXIMA;
                end else if (rodada == ultima) begin
                    prox = GANHOU;
                end else begin
                    prox = NOVA_RODADA;
                end
            end

            PROXIMA: begin
                jog_inc = 1'b1;
                prox    = ESPERA;
            end

            NOVA_RODADA: begin
                rod_inc = 1'b1;
                jog_clr = 1'b1;
                prox    = MOSTRA;
            end

            GANHOU, PERDEU, TIMEOUT: begin
                if (bus.jogar) begin
                    prox = PREPARA;
                end
            end

            default: begin
                prox = INICIAL;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Counters. Enables are gated by the terminal flag so a counter
    // saturates instead of wrapping if it ever reaches its top value.
    // ---------------------------------------------------------------
    contador_m #(
        .M (T_MAX + 1),
        .W (TW)
    ) u_timer (
        .clock (clock),
        .clr   (reset | (prox != estado)),
        .en    (~timer_fim),
        .q     (timer),
        .fim   (timer_fim)
    );

    contador_m #(
        .M (16),
        .W (4)
    ) u_jogada (
        .clock (clock),
        .clr   (reset | jog_clr),
        .en    (jog_inc & ~jogada_fim),
        .q     (jogada),
        .fim   (jogada_fim)
    );

    contador_m #(
        .M (16),
        .W (4)
    ) u_rodada (
        .clock (clock),
        .clr   (reset | (estado == PREPARA)),
        .en    (rod_inc & ~rodada_fim),
        .q     (rodada),
        .fim   (rodada_fim)
    );

    // ---------------------------------------------------------------
    // Game settings, captured once per game so later changes on
    // dificuldade/memoria only matter at the next start.
    // ---------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            ultima  <= 4'd0;
            banco_q <= 1'b0;
        end else if (estado == PREPARA) begin
            ultima  <= bus.dificuldade ? ULTIMA_DIFICIL : ULTIMA_FACIL;
            banco_q <= bus.memoria;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign bus.endereco    = jogada;
    assign bus.banco       = banco_q;
    assign bus.mostra_leds = (estado == MOSTRA) || (estado == APAGA);
    assign bus.led_aceso   = (estado == MOSTRA);
    assign bus.registra    = (estado == REGISTRA);
    assign bus.pronto      = (estado == GANHOU) || (estado == PERDEU) || (estado == TIMEOUT);
    assign bus.ganhou      = (estado == GANHOU);
    assign bus.perdeu      = (estado == PERDEU);
    assign bus.timeout     = (estado == TIMEOUT);
    assign bus.db_rodada   = rodada;
    assign bus.db_estado   = estado;

endmodule
